// File: rtl/latch_pkg.sv
// Shared types for the latch bank: global capture mode, one-shot channel states,
// and the capture decision used by every channel.
package latch_pkg;

  typedef enum logic [1:0] {
    TRANSPARENT = 2'd0,
    EDGE        = 2'd1,
    ONESHOT     = 2'd2,
    HOLD        = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } chan_state_e;

  localparam int          CNT_W   = 8;
  localparam logic [7:0]  CNT_MAX = 8'hFF;

  // LOCKED ignores latch_en, and IDLE never captures, even with a same-cycle arm.
  function automatic logic capture_req(input mode_e       mode,
                                       input logic        en,
                                       input logic        en_q,
                                       input chan_state_e state);
    logic req;
    req = 1'b0;
    unique case (mode)
      TRANSPARENT: req = en;
      EDGE:        req = en & ~en_q;
      ONESHOT:     req = en & (state == ARMED);
      HOLD:        req = 1'b0;
      default:     req = 1'b0;
    endcase
    return req;
  endfunction

endpackage

// File: rtl/latch_bank_chan.sv
// One latch channel: capture decision, one-shot FSM and registered outputs.
// Optional saturating capture counter when LATCH_BANK_CAPTURE_CNT_EN is defined.
//
//   state  | meaning
//   IDLE   | not armed; one-shot captures refused
//   ARMED  | next latch_en in ONESHOT captures and locks
//   LOCKED | value held; latch_en ignored until re-armed or cleared
module latch_bank_chan
  import latch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_latch_en,
  input  mode_e            i_mode,
  input  logic             i_arm,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_data,
  output logic             o_captured,
  output logic             o_locked
`ifdef LATCH_BANK_CAPTURE_CNT_EN
  ,
  output logic [CNT_W-1:0] o_capture_cnt
`endif
);

  chan_state_e      r_state;
  chan_state_e      w_state_nxt;
  logic             r_en_q;
  logic [WIDTH-1:0] r_data;
  logic             r_captured;
  logic             w_capture;

  always_comb begin
    w_capture   = 1'b0;
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = IDLE;
    end else begin
      w_capture = capture_req(i_mode, i_latch_en, r_en_q, r_state);
      // Outside ONESHOT the state is frozen so a mode change resumes where it left off.
      if (i_mode == ONESHOT) begin
        unique case (r_state)
          IDLE:    if (i_arm)      w_state_nxt = ARMED;
          ARMED:   if (i_latch_en) w_state_nxt = LOCKED;
          LOCKED:  if (i_arm)      w_state_nxt = ARMED;
          default:                 w_state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_q     <= 1'b0;
      r_data     <= '0;
      r_captured <= 1'b0;
    end else begin
      r_en_q     <= i_latch_en;
      r_captured <= w_capture;
      if (i_clear) begin
        r_data <= '0;
      end else if (w_capture) begin
        r_data <= i_data;
      end
    end
  end

`ifdef LATCH_BANK_CAPTURE_CNT_EN
  logic [CNT_W-1:0] r_capture_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_capture_cnt <= '0;
    end else if (i_clear) begin
      r_capture_cnt <= '0;
    end else if (w_capture && (r_capture_cnt != CNT_MAX)) begin
      r_capture_cnt <= r_capture_cnt + 1'b1;
    end
  end

  assign o_capture_cnt = r_capture_cnt;
`endif

  assign o_data     = r_data;
  assign o_captured = r_captured;
  assign o_locked   = (r_state == LOCKED);

endmodule

// File: rtl/latch_bank.sv
// Bank of CHANNELS independent latch channels sharing one global mode.
// Define LATCH_BANK_CAPTURE_CNT_EN to add the per-channel capture_cnt output.
module latch_bank
  import latch_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       latch_en,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       arm,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       captured,
  output logic [CHANNELS-1:0]       locked
`ifdef LATCH_BANK_CAPTURE_CNT_EN
  ,
  output logic [CHANNELS*CNT_W-1:0] capture_cnt
`endif
);

  mode_e w_mode;
  assign w_mode = mode_e'(mode);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    latch_bank_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_data       (data_in[g*WIDTH +: WIDTH]),
      .i_latch_en   (latch_en[g]),
      .i_mode       (w_mode),
      .i_arm        (arm[g]),
      .i_clear      (clear[g]),
      .o_data       (data_out[g*WIDTH +: WIDTH]),
      .o_captured   (captured[g]),
      .o_locked     (locked[g])
`ifdef LATCH_BANK_CAPTURE_CNT_EN
      ,
      .o_capture_cnt(capture_cnt[g*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: doc/latch_bank.md
LATCH_BANK -- requirements
Module: latch_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data bits per channel (1..64).
REQ-002 SHALL have parameter CHANNELS, default 4, meaning the number of independent latch channels (1..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port data_in, input, CHANNELS x WIDTH bits: per-channel capture data.
REQ-006 SHALL have port latch_en, input, CHANNELS bits: per-channel capture enable.
REQ-007 SHALL have port mode, input, 2 bits, global: 0 TRANSPARENT, 1 EDGE, 2 ONESHOT, 3 HOLD.
REQ-008 SHALL have port arm, input, CHANNELS bits: per-channel one-shot arm pulse.
REQ-009 SHALL have port clear, input, CHANNELS bits: per-channel synchronous clear.
REQ-010 SHALL have port data_out, output, CHANNELS x WIDTH bits: registered held value per channel.
REQ-011 SHALL have port captured, output, CHANNELS bits: set for exactly one cycle after a capture.
REQ-012 SHALL have port locked, output, CHANNELS bits: high while the channel is in LOCKED.

Function
REQ-013 All outputs SHALL be registered; a capture at edge N SHALL appear on data_out after edge N (1-cycle latency).
REQ-014 TRANSPARENT mode: the channel SHALL capture data_in on every edge where latch_en=1 and hold otherwise.
REQ-015 EDGE mode: the channel SHALL capture only on an edge where latch_en=1 and the registered en_q=0; en_q updates every cycle in all modes.
REQ-016 ONESHOT mode: a per-channel FSM SHALL run with states IDLE, ARMED and LOCKED.
REQ-017 ONESHOT transitions: IDLE->ARMED on arm=1; ARMED->LOCKED with capture on latch_en=1; LOCKED->ARMED on arm=1; any state->IDLE on clear=1.
REQ-018 ONESHOT simultaneous events: arm=1 and latch_en=1 in IDLE SHALL go to ARMED without capturing; in LOCKED, latch_en SHALL be ignored.
REQ-019 HOLD mode: no channel SHALL capture; FSM state SHALL be frozen except for clear.
REQ-020 On a mode change, FSM state SHALL be retained; the FSM SHALL only advance while mode=ONESHOT (or on clear).
REQ-021 clear=1 SHALL set data_out to 0, captured to 0 and the FSM to IDLE, overriding a same-cycle capture or arm.
REQ-022 captured SHALL pulse for exactly one cycle per capture; back-to-back TRANSPARENT captures SHALL hold it high on consecutive cycles.
REQ-023 Channels SHALL be fully independent; there SHALL be no cross-channel priority.

Reset
REQ-024 rst_n=0 SHALL asynchronously force data_out=0, captured=0, locked=0, en_q=0, FSM=IDLE (and capture counters=0 when compiled in).
REQ-025 Reset asserted mid-operation SHALL discard any in-flight capture; the first capture SHALL occur no earlier than the first edge after rst_n deasserts.

Configuration
REQ-026 Macro LATCH_BANK_CAPTURE_CNT_EN defined: the block SHALL add output capture_cnt, CHANNELS x 8 bits, holding per-channel saturating capture counts (stick at 255), zeroed by clear or reset.
REQ-027 Macro LATCH_BANK_CAPTURE_CNT_EN undefined: the capture_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package latch_pkg SHALL hold the mode enum (TRANSPARENT, EDGE, ONESHOT, HOLD) and the FSM state enum (IDLE, ARMED, LOCKED).
REQ-029 A sub-module latch_bank_chan SHALL implement one channel; latch_bank SHALL instantiate it CHANNELS times in a generate loop.

Verification
REQ-030 TRANSPARENT: latch_en[0]=1 for 3 cycles with data 0x11, 0x22, 0x33 -> data_out[0] follows one cycle later and ends at 0x33; captured[0] is high for 3 cycles.
REQ-031 EDGE: latch_en[1] held at 1 for 5 cycles, data 0xA5 then 0x5A -> one capture of 0xA5, one captured pulse, data_out[1] stays 0xA5.
REQ-032 ONESHOT: arm[2] pulse, then latch_en[2]=1 twice with 0x7E then 0x81 -> data_out[2]=0x7E, locked[2]=1; re-arm, then en with 0x81 -> 0x81.
REQ-033 Simultaneous: clear[3] and latch_en[3]=1 in TRANSPARENT -> data_out[3]=0, captured[3]=0; arm+en in IDLE -> ARMED, no capture.
REQ-034 Reset mid-operation: rst_n low between clock edges while locked=1 -> outputs zero immediately; with the macro defined, 300 captures -> capture_cnt=255.
